// File: rtl/load_distributor.sv
// -----------------------------------------------------------------------------
// load_distributor
//
// Receiving end of the coordinate-generator handshake in the lab 4 fractal
// pipeline. Each accepted transfer (one complex-plane coordinate plus its VGA
// pixel position) is dispatched to the lowest-index idle Mandelbrot iterator
// core. Iteration counts coming back from the cores are collected and
// presented, tagged with their pixel position, one at a time to the
// downstream VGA memory writer.
//
// Parameters:
//   NUM_CORES     number of iterator cores (1-16)
//   ITER_W        width of a core's iteration count
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   oCoordGenRdy  distributor can accept a coordinate (registered)
//   iCoordValid   generator holds a valid coordinate
//   iVGAX/iVGAY   pixel column/row tag travelling with the coordinate
//   iCoordX/Y     real/imaginary coordinate, passed through unchanged
//   oCoreStart    one-hot, one-cycle start pulse to the chosen core
//   oCoreX/Y      coordinate broadcast to the cores, valid with oCoreStart
//   iCoreDone     per-core one-cycle completion pulse
//   iCoreIter     per-core iteration count, core i at [i*ITER_W +: ITER_W]
//   oPixelValid   a tagged result is presented to the writer
//   oPixelX/Y     result pixel column/row
//   oPixelIter    result iteration count
//   iPixelRdy     writer accepts the presented result
//
// Optional feature (macro LOAD_DIST_STATS_EN):
//   oPixelCount   19-bit count of accepted results, wraps 307199 -> 0
//   oFrameDone    one-cycle pulse on that wrap (one full 640x480 frame)
// With the macro undefined neither port nor the counter exists.
// -----------------------------------------------------------------------------
module load_distributor #(
  parameter int NUM_CORES = 4,
  parameter int ITER_W    = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        oCoordGenRdy,
  input  logic                        iCoordValid,
  input  logic [9:0]                  iVGAX,
  input  logic [8:0]                  iVGAY,
  input  logic [35:0]                 iCoordX,
  input  logic [35:0]                 iCoordY,
  output logic [NUM_CORES-1:0]        oCoreStart,
  output logic [35:0]                 oCoreX,
  output logic [35:0]                 oCoreY,
  input  logic [NUM_CORES-1:0]        iCoreDone,
  input  logic [NUM_CORES*ITER_W-1:0] iCoreIter,
  output logic                        oPixelValid,
  output logic [9:0]                  oPixelX,
  output logic [8:0]                  oPixelY,
  output logic [ITER_W-1:0]           oPixelIter,
  input  logic                        iPixelRdy
`ifdef LOAD_DIST_STATS_EN
  ,
  output logic [18:0]                 oPixelCount,
  output logic                        oFrameDone
`endif
);

  // Per-core bookkeeping. busy: core is iterating. pending: core finished and
  // its result is waiting to be moved into the output register.
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] busyNext;
  logic [NUM_CORES-1:0] pendingNext;

  logic [9:0]        tagX    [NUM_CORES];
  logic [8:0]        tagY    [NUM_CORES];
  logic [ITER_W-1:0] iterReg [NUM_CORES];

  logic [NUM_CORES-1:0] freeNow;
  logic [NUM_CORES-1:0] completing;
  logic [NUM_CORES-1:0] drainable;
  logic [NUM_CORES-1:0] startSel;
  logic [NUM_CORES-1:0] drainSel;

  logic              accept;
  logic              loadOut;
  logic              drainAny;
  logic [9:0]        drainX;
  logic [8:0]        drainY;
  logic [ITER_W-1:0] drainIter;

  // Handshake and per-cycle status vectors. A done pulse only counts for a
  // core that is actually iterating; stray pulses on idle or waiting cores
  // are dropped here. A result completing this cycle is already drainable,
  // so a finished core can reach the output register on the same edge.
  always_comb begin
    accept     = iCoordValid && oCoordGenRdy;
    freeNow    = ~busy & ~pending;
    completing = iCoreDone & busy;
    drainable  = pending | completing;
    loadOut    = !oPixelValid || iPixelRdy;
  end

  // Lowest-index selection for dispatch and for drain. Scanning from the top
  // down and restarting the one-hot vector on every hit leaves the lowest
  // qualifying index selected. oCoordGenRdy only rises when a core is free,
  // so startSel is never empty when a transfer is accepted.
  always_comb begin
    startSel = '0;
    drainSel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (freeNow[i]) begin
        startSel    = '0;
        startSel[i] = 1'b1;
      end
      if (drainable[i] && loadOut) begin
        drainSel    = '0;
        drainSel[i] = 1'b1;
      end
    end
  end

  // Result multiplexer for the selected drain core. A core finishing on this
  // very edge has not latched its count yet, so take it straight from the
  // core's output bus in that case.
  always_comb begin
    drainAny  = |drainSel;
    drainX    = '0;
    drainY    = '0;
    drainIter = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (drainSel[i]) begin
        drainX    = tagX[i];
        drainY    = tagY[i];
        drainIter = completing[i] ? iCoreIter[i*ITER_W +: ITER_W] : iterReg[i];
      end
    end
  end

  // Next busy/pending state. Dispatch only ever picks a free core and drain
  // only ever picks a finished one, so the three updates never touch the same
  // core bit in conflicting ways.
  always_comb begin
    busyNext    = busy & ~completing;
    pendingNext = (pending | completing) & ~drainSel;
    if (accept) begin
      busyNext = busyNext | startSel;
    end
  end

  // Core state registers plus the registered ready flag. Ready looks at the
  // state after this edge's updates, so a core drained at edge T shows up as
  // ready from T+1, and the flag first rises one cycle after reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= '0;
      pending      <= '0;
      oCoordGenRdy <= 1'b0;
    end else begin
      busy         <= busyNext;
      pending      <= pendingNext;
      oCoordGenRdy <= |(~busyNext & ~pendingNext);
    end
  end

  // Per-core tag and iteration storage. These are pure data registers whose
  // contents are only meaningful while the matching busy/pending bit is set,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (accept && startSel[i]) begin
        tagX[i] <= iVGAX;
        tagY[i] <= iVGAY;
      end
      if (completing[i]) begin
        iterReg[i] <= iCoreIter[i*ITER_W +: ITER_W];
      end
    end
  end

  // Dispatch to the cores: a one-cycle start pulse and the coordinate itself,
  // both registered so they line up in the cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      oCoreStart <= '0;
      oCoreX     <= '0;
      oCoreY     <= '0;
    end else begin
      oCoreStart <= accept ? startSel : '0;
      if (accept) begin
        oCoreX <= iCoordX;
        oCoreY <= iCoordY;
      end
    end
  end

  // Single-entry output register toward the memory writer. It reloads when
  // empty or when its current result is being taken, which gives one result
  // per cycle under continuous iPixelRdy. Under backpressure nothing here
  // changes, so the presented result stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      oPixelValid <= 1'b0;
      oPixelX     <= '0;
      oPixelY     <= '0;
      oPixelIter  <= '0;
    end else if (loadOut) begin
      oPixelValid <= drainAny;
      if (drainAny) begin
        oPixelX    <= drainX;
        oPixelY    <= drainY;
        oPixelIter <= drainIter;
      end
    end
  end

`ifdef LOAD_DIST_STATS_EN
  localparam logic [18:0] FRAME_LAST = 19'd307199;

  // Frame statistics: count results taken by the writer and flag each
  // completed 640x480 frame with a one-cycle pulse as the count wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      oPixelCount <= '0;
      oFrameDone  <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;
      if (oPixelValid && iPixelRdy) begin
        if (oPixelCount == FRAME_LAST) begin
          oPixelCount <= '0;
          oFrameDone  <= 1'b1;
        end else begin
          oPixelCount <= oPixelCount + 19'd1;
        end
      end
    end
  end
`endif

endmodule
